// File: rtl/fetch2decode_queue_pkg.sv
// Shared definitions for the Fetch-2 -> Decode elastic queue.
//   - Default configuration constants (lanes, packet width, depth, update width).
//   - f2d_bundle_t : one decode bundle {lane_v, pkt[FETCH_WIDTH]} at default sizes.
//   - f2d_upd_t    : packed predictor-update bundle {pc,npc,ctrl_type,dir,counter,index}.
//   - f2d_ptr_inc  : circular pointer increment for any (non power of 2) depth.
package fetch2decode_queue_pkg;

  localparam int F2D_FETCH_WIDTH = 4;
  localparam int F2D_PKT_W       = 64;
  localparam int F2D_DEPTH       = 4;
  localparam int F2D_UPD_W       = 80;

  typedef struct packed {
    logic [F2D_FETCH_WIDTH-1:0]                lane_v;
    logic [F2D_FETCH_WIDTH-1:0][F2D_PKT_W-1:0] pkt;
  } f2d_bundle_t;

  // 32 + 32 + 3 + 1 + 2 + 10 = 80 bits, matching F2D_UPD_W.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [2:0]  ctrl_type;
    logic        dir;
    logic [1:0]  counter;
    logic [9:0]  index;
  } f2d_upd_t;

  // Wraps DEPTH-1 -> 0 so the queue works for any depth, not only powers of 2.
  function automatic int unsigned f2d_ptr_inc(input int unsigned ptr,
                                              input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fetch2decode_queue_ctrl.sv
// f2d_queue_ctrl: pointer/occupancy control for the Fetch-2 -> Decode queue.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   flush_i        discard everything; wins over push and pop
//   in_valid_i     fetch offers a bundle
//   any_lane_i     offered bundle has at least one effective lane
//   out_ready_i    decode consumes the head
//   in_ready_o     count < DEPTH (registered count only)
//   out_valid_o    count != 0
//   push_o/pop_o   qualified write / read strobes for the storage
//   wr_ptr_o/rd_ptr_o  circular pointers
//   count_o        occupancy
module f2d_queue_ctrl
  import fetch2decode_queue_pkg::*;
#(
  parameter int DEPTH = F2D_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic                       any_lane_i,
  input  logic                       out_ready_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic                       push_o,
  output logic                       pop_o,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Ready depends only on registered count: a pop in a full cycle does not
  // open a slot until the next cycle, keeping in_ready off the stall path.
  assign in_ready_o  = (count_q < CW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  // Zero-lane bundles complete the handshake (in_ready) but are not stored.
  assign push_o      = in_valid_i & in_ready_o & any_lane_i & ~flush_i;
  assign pop_o       = out_valid_o & out_ready_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_o) wr_ptr_d = PW'(f2d_ptr_inc(int'(wr_ptr_q), DEPTH));
      if (pop_o)  rd_ptr_d = PW'(f2d_ptr_inc(int'(rd_ptr_q), DEPTH));
      if (push_o && !pop_o)      count_d = count_q + CW'(1);
      else if (pop_o && !push_o) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/fetch2decode_queue.sv
// fetch2decode_queue: elastic DEPTH-entry circular queue of FETCH_WIDTH-lane
// decode bundles between Fetch-2 and Decode, plus a one-cycle register stage
// for the branch-predictor update bundle heading back to Fetch.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   lane_active_i               lane enable mask (only with F2D_LANE_GATE_EN)
//   flush_i                     discard all queued bundles and the offered one
//   in_valid_i/in_ready_o       fetch-side valid/ready
//   in_lane_v_i, in_pkt_i       offered bundle (lane0 at LSBs)
//   out_valid_o/out_ready_i     decode-side valid/ready
//   out_lane_v_o, out_pkt_o     head bundle (zero when empty)
//   count_o                     occupancy
//   upd_en_i/upd_i -> upd_en_o/upd_o   predictor update, delayed one cycle
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high and flush_i is low; ready never depends on the same-cycle valid.
// Build option: define F2D_LANE_GATE_EN to add lane_active_i, per-lane write
// enables and output isolation of inactive lanes.
module fetch2decode_queue
  import fetch2decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = F2D_FETCH_WIDTH,
  parameter int PKT_W       = F2D_PKT_W,
  parameter int DEPTH       = F2D_DEPTH,
  parameter int UPD_W       = F2D_UPD_W
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef F2D_LANE_GATE_EN
  input  logic [FETCH_WIDTH-1:0]       lane_active_i,
`endif
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [FETCH_WIDTH-1:0]       in_lane_v_i,
  input  logic [FETCH_WIDTH*PKT_W-1:0] in_pkt_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [FETCH_WIDTH-1:0]       out_lane_v_o,
  output logic [FETCH_WIDTH*PKT_W-1:0] out_pkt_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  input  logic                         upd_en_i,
  input  logic [UPD_W-1:0]             upd_i,
  output logic                         upd_en_o,
  output logic [UPD_W-1:0]             upd_o
);

  localparam int PW = $clog2(DEPTH);

  logic [FETCH_WIDTH-1:0] lane_act;
  logic [FETCH_WIDTH-1:0] eff_v;
  logic                   push, pop;
  logic [PW-1:0]          wr_ptr, rd_ptr;

`ifdef F2D_LANE_GATE_EN
  assign lane_act = lane_active_i;
`else
  assign lane_act = '1;
`endif

  assign eff_v = in_lane_v_i & lane_act;

  f2d_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .any_lane_i  (|eff_v),
    .out_ready_i (out_ready_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .push_o      (push),
    .pop_o       (pop),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count_o)
  );

  // Bundle storage; not reset, since the count alone decides what is live.
  logic [FETCH_WIDTH-1:0] lane_v_q [DEPTH];
  logic [FETCH_WIDTH-1:0] lane_v_d [DEPTH];
  logic [PKT_W-1:0]       pkt_q    [DEPTH][FETCH_WIDTH];
  logic [PKT_W-1:0]       pkt_d    [DEPTH][FETCH_WIDTH];

  always_comb begin
    lane_v_d = lane_v_q;
    pkt_d    = pkt_q;
    if (push) begin
      lane_v_d[wr_ptr] = eff_v;
      for (int l = 0; l < FETCH_WIDTH; l++) begin
`ifdef F2D_LANE_GATE_EN
        // Powered-down lanes keep their old contents.
        if (eff_v[l]) pkt_d[wr_ptr][l] = in_pkt_i[l*PKT_W +: PKT_W];
`else
        pkt_d[wr_ptr][l] = in_pkt_i[l*PKT_W +: PKT_W];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    lane_v_q <= lane_v_d;
    pkt_q    <= pkt_d;
  end

  // Head is zeroed when empty so reset and idle outputs are clean.
  // Lane-valid is re-masked with the live lane_act to isolate lanes that were
  // switched off while their bundle sat in the queue.
  always_comb begin
    out_lane_v_o = '0;
    out_pkt_o    = '0;
    if (out_valid_o) begin
      out_lane_v_o = lane_v_q[rd_ptr] & lane_act;
      for (int l = 0; l < FETCH_WIDTH; l++) begin
        out_pkt_o[l*PKT_W +: PKT_W] = pkt_q[rd_ptr][l];
      end
    end
  end

  // Predictor update path: plain register, only reset affects it.
  logic             upd_en_q, upd_en_d;
  logic [UPD_W-1:0] upd_q, upd_d;

  always_comb begin
    upd_en_d = upd_en_i;
    upd_d    = upd_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_en_q <= 1'b0;
      upd_q    <= '0;
    end else begin
      upd_en_q <= upd_en_d;
      upd_q    <= upd_d;
    end
  end

  assign upd_en_o = upd_en_q;
  assign upd_o    = upd_q;

endmodule

// File: tb/tb_fetch2decode_queue.sv
module tb_fetch2decode_queue;

  localparam int FW = 4;
  localparam int PW = 64;
  localparam int UW = 80;
  localparam int BW = FW + FW*PW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, flush, in_valid, out_ready, upd_en_in;
  logic [FW-1:0]  in_lane_v, lane_active;
  logic [FW*PW-1:0] in_pkt;
  logic [UW-1:0]  upd_in;

  logic           in_ready_a, out_valid_a, upd_en_a;
  logic [FW-1:0]  out_lane_v_a;
  logic [FW*PW-1:0] out_pkt_a;
  logic [2:0]     count_a;
  logic [UW-1:0]  upd_a;

  logic           in_ready_b, out_valid_b, upd_en_b;
  logic [FW-1:0]  out_lane_v_b;
  logic [FW*PW-1:0] out_pkt_b;
  logic [1:0]     count_b;
  logic [UW-1:0]  upd_b;

  fetch2decode_queue #(.FETCH_WIDTH(FW), .PKT_W(PW), .DEPTH(4), .UPD_W(UW)) dut_a (
    .clk(clk), .reset(reset),
`ifdef F2D_LANE_GATE_EN
    .lane_active_i(lane_active),
`endif
    .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
    .in_lane_v_i(in_lane_v), .in_pkt_i(in_pkt),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .out_lane_v_o(out_lane_v_a), .out_pkt_o(out_pkt_a), .count_o(count_a),
    .upd_en_i(upd_en_in), .upd_i(upd_in), .upd_en_o(upd_en_a), .upd_o(upd_a)
  );

  fetch2decode_queue #(.FETCH_WIDTH(FW), .PKT_W(PW), .DEPTH(3), .UPD_W(UW)) dut_b (
    .clk(clk), .reset(reset),
`ifdef F2D_LANE_GATE_EN
    .lane_active_i(lane_active),
`endif
    .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .in_lane_v_i(in_lane_v), .in_pkt_i(in_pkt),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .out_lane_v_o(out_lane_v_b), .out_pkt_o(out_pkt_b), .count_o(count_b),
    .upd_en_i(upd_en_in), .upd_i(upd_in), .upd_en_o(upd_en_b), .upd_o(upd_b)
  );

  // ---------------- scoreboard / reference model ----------------
  // Each queue entry is {lane_v, pkt}; index 0 models DEPTH=4, index 1 DEPTH=3.
  logic [BW-1:0] exp_q [2][$];
  int            depth_m [2] = '{4, 3};
  logic          exp_upd_en;
  logic [UW-1:0] exp_upd;
  int            checks = 0;
  int            errors = 0;
  bit            force_upd = 1'b0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic check_dut(input int d, input string nm, input logic [2:0] cnt,
                           input logic rdy, input logic vld, input logic [FW-1:0] lv,
                           input logic [FW*PW-1:0] pkt, input logic ue, input logic [UW-1:0] u);
    int n;
    logic [BW-1:0]    head;
    logic [FW-1:0]    elv;
    logic [FW*PW-1:0] mask;
    n = exp_q[d].size();
    check({nm, "_count"}, 256'(cnt), 256'(n));
    check({nm, "_in_ready"}, 256'(rdy), 256'(n < depth_m[d]));
    check({nm, "_out_valid"}, 256'(vld), 256'(n > 0));
    if (n > 0) begin
      head = exp_q[d][0];
      elv  = head[BW-1 -: FW] & lane_active;
      mask = '0;
      for (int l = 0; l < FW; l++) if (elv[l]) mask[l*PW +: PW] = '1;
      check({nm, "_lane_v"}, 256'(lv), 256'(elv));
      check({nm, "_pkt"}, 256'(pkt & mask), 256'(head[FW*PW-1:0] & mask));
    end else begin
      check({nm, "_lane_v_empty"}, 256'(lv), 256'(0));
    end
    check({nm, "_upd_en"}, 256'(ue), 256'(exp_upd_en));
    check({nm, "_upd"}, 256'(u), 256'(exp_upd));
  endtask

  // Next-state of the reference: a FIFO of accepted non-empty bundles.
  task automatic model_step();
    logic [FW-1:0] eff;
    int n;
    eff = in_lane_v & lane_active;
    for (int d = 0; d < 2; d++) begin
      n = exp_q[d].size();
      if (reset || flush) begin
        exp_q[d].delete();
      end else begin
        if (n > 0 && out_ready) exp_q[d].delete(0);
        if (in_valid && n < depth_m[d] && eff != '0) exp_q[d].push_back({eff, in_pkt});
      end
    end
    exp_upd_en = reset ? 1'b0 : upd_en_in;
    exp_upd    = reset ? '0 : upd_in;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rs, input logic fl, input logic iv,
                      input logic [FW-1:0] lv, input logic orr);
    reset     = rs;
    flush     = fl;
    in_valid  = iv;
    in_lane_v = lv;
    out_ready = orr;
    for (int i = 0; i < FW*PW/32; i++) in_pkt[i*32 +: 32] = $urandom;
    if (force_upd) begin
      upd_en_in = 1'b1;
      upd_in    = 80'hABC;
    end else begin
      upd_en_in = 1'($urandom_range(0, 1));
      upd_in    = {16'($urandom), $urandom, $urandom};
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_dut(0, "d4", count_a, in_ready_a, out_valid_a, out_lane_v_a, out_pkt_a, upd_en_a, upd_a);
    check_dut(1, "d3", {1'b0, count_b}, in_ready_b, out_valid_b, out_lane_v_b, out_pkt_b, upd_en_b, upd_b);
  endtask

  function automatic logic [FW-1:0] rnd_lanes();
    return FW'($urandom_range(1, (1 << FW) - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_lane_v = '0; in_pkt = '0; upd_en_in = 1'b0; upd_in = '0;
    lane_active = '1;
    exp_upd_en = 1'b0; exp_upd = '0;
    @(negedge clk);
    step(1, 0, 0, 4'h0, 0);
    step(1, 0, 1, 4'hF, 1);
    check("rst_out_pkt", 256'(out_pkt_a), 256'(0));
    check("rst_in_ready", 256'(in_ready_a), 256'(1));

    // Fill / drain: 5 offers with decode stalled, then drain.
    for (int i = 0; i < 5; i++) step(0, 0, 1, rnd_lanes(), 0);
    check("fill_count", 256'(count_a), 256'(4));
    check("fill_ready", 256'(in_ready_a), 256'(0));
    for (int i = 0; i < 5; i++) step(0, 0, 0, 4'h0, 1);

    // Simultaneous push+pop at count 2.
    step(0, 0, 1, rnd_lanes(), 0);
    step(0, 0, 1, rnd_lanes(), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, rnd_lanes(), 1);
    check("pushpop_count", 256'(count_a), 256'(2));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'h0, 1);

    // Full + pop: push refused that cycle.
    for (int i = 0; i < 4; i++) step(0, 0, 1, rnd_lanes(), 0);
    step(0, 0, 1, rnd_lanes(), 1);
    check("fullpop_count", 256'(count_a), 256'(3));
    check("fullpop_ready", 256'(in_ready_a), 256'(1));

    // Flush at count 3 with an offered bundle; update path keeps flowing.
    force_upd = 1'b1;
    step(0, 1, 1, 4'hF, 1);
    force_upd = 1'b0;
    check("flush_count", 256'(count_a), 256'(0));
    check("flush_valid", 256'(out_valid_a), 256'(0));
    check("flush_upd", 256'(upd_a), 256'(80'hABC));
    check("flush_upd_en", 256'(upd_en_a), 256'(1));

    // Zero-lane bundle: accepted, not stored.
    step(0, 0, 1, 4'h0, 0);
    check("zero_lane_count", 256'(count_a), 256'(0));
    check("zero_lane_ready", 256'(in_ready_a), 256'(1));

    // Push/pop streaming to exercise pointer wrap on both depths.
    for (int i = 0; i < 12; i++) step(0, 0, 1, rnd_lanes(), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h0, 1);

`ifdef F2D_LANE_GATE_EN
    lane_active = 4'b0011;
    step(0, 0, 1, 4'hF, 0);
    check("gate_lane_v", 256'(out_lane_v_a), 256'(4'b0011));
    lane_active = 4'b0001;
    step(0, 0, 0, 4'h0, 0);
    check("gate_iso_lane_v", 256'(out_lane_v_a), 256'(4'b0001));
    step(0, 1, 0, 4'h0, 0);
    lane_active = '1;
`endif

    // Randomized traffic with occasional flush and mid-run reset.
    for (int i = 0; i < 400; i++) begin
`ifdef F2D_LANE_GATE_EN
      if ($urandom_range(0, 15) == 0) lane_active = FW'($urandom_range(0, 15));
`endif
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 3) != 0), FW'($urandom_range(0, 15)),
           1'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
